// File: rtl/fpnew_opgroup_inorder_block.sv
// In-order result collector: steers dispatch to NumLanes lane slices and retires their results in issue order.
// Optional single-entry output register after the retire mux: define FPNEW_INORDER_OUTREG_EN.
`timescale 1ns/1ps
module fpnew_opgroup_inorder_block #(
  parameter int unsigned Width    = 32,
  parameter int unsigned NumLanes = 5,
  parameter int unsigned Depth    = 8,
  parameter int unsigned TagWidth = 1,
  localparam int unsigned LaneIdxW = (NumLanes > 1) ? $clog2(NumLanes) : 1,
  localparam int unsigned CntW     = $clog2(Depth + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         in_valid_i,
  input  logic [LaneIdxW-1:0]          in_lane_i,
  output logic                         in_ready_o,
  input  logic                         flush_i,
  output logic [NumLanes-1:0]          lane_in_valid_o,
  input  logic [NumLanes-1:0]          lane_in_ready_i,
  input  logic [NumLanes-1:0]          lane_out_valid_i,
  output logic [NumLanes-1:0]          lane_out_ready_o,
  input  logic [NumLanes*Width-1:0]    lane_result_i,
  input  logic [NumLanes*5-1:0]        lane_status_i,
  input  logic [NumLanes-1:0]          lane_ext_bit_i,
  input  logic [NumLanes*TagWidth-1:0] lane_tag_i,
  input  logic [NumLanes-1:0]          lane_busy_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [Width-1:0]             result_o,
  output logic [4:0]                   status_o,
  output logic                         extension_bit_o,
  output logic [TagWidth-1:0]          tag_o,
  output logic                         busy_o,
  output logic                         order_err_o,
  output logic [CntW-1:0]              occupancy_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [LaneIdxW-1:0] fifo_q [Depth];
  logic [LaneIdxW-1:0] fifo_d [Depth];
  logic [PtrW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [CntW-1:0]     lane_cnt_q [NumLanes];
  logic [CntW-1:0]     lane_cnt_d [NumLanes];
  logic                order_err_q, order_err_d;

  logic                empty_s, full_s, dispatch_s, in_range_s, sel_in_rdy_s;
  logic                push_s, pop_s, take_s, fifo_vld_s;
  logic [LaneIdxW-1:0] head_lane_s;
  logic                head_vld_s;
  logic [Width-1:0]    head_res_s;
  logic [4:0]          head_status_s;
  logic                head_ext_s;
  logic [TagWidth-1:0] head_tag_s;

  // Dispatch steering; out-of-range lane indices match no lane and are never accepted
  always_comb begin
    empty_s         = (count_q == CntW'(0));
    full_s          = (count_q == CntW'(Depth));
    dispatch_s      = in_valid_i & ~full_s & ~flush_i;
    in_range_s      = 1'b0;
    sel_in_rdy_s    = 1'b0;
    lane_in_valid_o = {NumLanes{1'b0}};
    for (int l = 0; l < NumLanes; l++) begin
      if (in_lane_i == LaneIdxW'(l)) begin
        in_range_s         = 1'b1;
        sel_in_rdy_s       = lane_in_ready_i[l];
        lane_in_valid_o[l] = dispatch_s;
      end else begin
        lane_in_valid_o[l] = 1'b0;
      end
    end
    in_ready_o = dispatch_s & in_range_s & sel_in_rdy_s;
    push_s     = in_valid_i & in_ready_o;
  end

  // Retire mux: only the lane named at the FIFO head may hand over a result
  always_comb begin
    head_lane_s      = fifo_q[head_q];
    head_vld_s       = 1'b0;
    head_res_s       = {Width{1'b0}};
    head_status_s    = 5'b00000;
    head_ext_s       = 1'b0;
    head_tag_s       = {TagWidth{1'b0}};
    lane_out_ready_o = {NumLanes{1'b0}};
    for (int l = 0; l < NumLanes; l++) begin
      if (head_lane_s == LaneIdxW'(l)) begin
        head_vld_s          = lane_out_valid_i[l];
        head_res_s          = lane_result_i[l*Width +: Width];
        head_status_s       = lane_status_i[l*5 +: 5];
        head_ext_s          = lane_ext_bit_i[l];
        head_tag_s          = lane_tag_i[l*TagWidth +: TagWidth];
        lane_out_ready_o[l] = take_s & ~empty_s & ~flush_i;
      end else begin
        lane_out_ready_o[l] = 1'b0;
      end
    end
    fifo_vld_s = ~empty_s & head_vld_s;
    pop_s      = fifo_vld_s & take_s & ~flush_i;
  end

  // Ordering FIFO, occupancy, per-lane outstanding counters and sticky order error
  always_comb begin
    fifo_d      = fifo_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    lane_cnt_d  = lane_cnt_q;
    order_err_d = order_err_q;
    if (flush_i) begin
      head_d      = {PtrW{1'b0}};
      tail_d      = {PtrW{1'b0}};
      count_d     = {CntW{1'b0}};
      order_err_d = 1'b0;
      for (int l = 0; l < NumLanes; l++) begin
        lane_cnt_d[l] = {CntW{1'b0}};
      end
    end else begin
      if (push_s) begin
        fifo_d[tail_q] = in_lane_i;
        tail_d         = tail_q + PtrW'(1);
      end else begin
        tail_d = tail_q;
      end
      if (pop_s) begin
        head_d = head_q + PtrW'(1);
      end else begin
        head_d = head_q;
      end
      count_d = count_q + {{(CntW-1){1'b0}}, push_s} - {{(CntW-1){1'b0}}, pop_s};
      for (int l = 0; l < NumLanes; l++) begin
        lane_cnt_d[l] = lane_cnt_q[l]
                      + {{(CntW-1){1'b0}}, (push_s && in_lane_i == LaneIdxW'(l))}
                      - {{(CntW-1){1'b0}}, (pop_s && head_lane_s == LaneIdxW'(l))};
        // A lane with nothing outstanding must never offer a result
        if (lane_out_valid_i[l] && lane_cnt_q[l] == CntW'(0)) begin
          order_err_d = 1'b1;
        end else begin
          order_err_d = order_err_d;
        end
      end
    end
  end

  // Ordering state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q      <= {PtrW{1'b0}};
      tail_q      <= {PtrW{1'b0}};
      count_q     <= {CntW{1'b0}};
      order_err_q <= 1'b0;
      for (int i = 0; i < Depth; i++) begin
        fifo_q[i] <= {LaneIdxW{1'b0}};
      end
      for (int l = 0; l < NumLanes; l++) begin
        lane_cnt_q[l] <= {CntW{1'b0}};
      end
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      order_err_q <= order_err_d;
      fifo_q      <= fifo_d;
      lane_cnt_q  <= lane_cnt_d;
    end
  end

  assign order_err_o = order_err_q;
  assign occupancy_o = count_q;

`ifdef FPNEW_INORDER_OUTREG_EN
  logic                oreg_vld_q, oreg_vld_d;
  logic [Width-1:0]    oreg_res_q, oreg_res_d;
  logic [4:0]          oreg_status_q, oreg_status_d;
  logic                oreg_ext_q, oreg_ext_d;
  logic [TagWidth-1:0] oreg_tag_q, oreg_tag_d;

  assign take_s = ~oreg_vld_q | out_ready_i;

  // Output register refills on every pop and empties when drained without a refill
  always_comb begin
    oreg_vld_d    = oreg_vld_q;
    oreg_res_d    = oreg_res_q;
    oreg_status_d = oreg_status_q;
    oreg_ext_d    = oreg_ext_q;
    oreg_tag_d    = oreg_tag_q;
    if (flush_i) begin
      oreg_vld_d = 1'b0;
    end else if (take_s) begin
      oreg_vld_d = pop_s;
      if (pop_s) begin
        oreg_res_d    = head_res_s;
        oreg_status_d = head_status_s;
        oreg_ext_d    = head_ext_s;
        oreg_tag_d    = head_tag_s;
      end else begin
        oreg_res_d = oreg_res_q;
      end
    end else begin
      oreg_vld_d = oreg_vld_q;
    end
  end

  // Output register state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      oreg_vld_q    <= 1'b0;
      oreg_res_q    <= {Width{1'b0}};
      oreg_status_q <= 5'b00000;
      oreg_ext_q    <= 1'b0;
      oreg_tag_q    <= {TagWidth{1'b0}};
    end else begin
      oreg_vld_q    <= oreg_vld_d;
      oreg_res_q    <= oreg_res_d;
      oreg_status_q <= oreg_status_d;
      oreg_ext_q    <= oreg_ext_d;
      oreg_tag_q    <= oreg_tag_d;
    end
  end

  assign out_valid_o     = oreg_vld_q;
  assign result_o        = oreg_res_q;
  assign status_o        = oreg_status_q;
  assign extension_bit_o = oreg_ext_q;
  assign tag_o           = oreg_tag_q;
  assign busy_o          = ~empty_s | (|lane_busy_i) | oreg_vld_q;
`else
  assign take_s          = out_ready_i;
  assign out_valid_o     = fifo_vld_s;
  assign result_o        = head_res_s;
  assign status_o        = head_status_s;
  assign extension_bit_o = head_ext_s;
  assign tag_o           = head_tag_s;
  assign busy_o          = ~empty_s | (|lane_busy_i);
`endif

endmodule

// File: tb/tb_fpnew_opgroup_inorder_block.sv
// Bench for fpnew_opgroup_inorder_block: lane slices modelled from an issue-order queue, scoreboard at negedge.
`timescale 1ns/1ps
module tb_fpnew_opgroup_inorder_block;
  localparam int W = 32, NL = 5, D = 8, TW = 1, LW = 3, CW = 4;
`ifdef FPNEW_INORDER_OUTREG_EN
  localparam bit OUTREG = 1'b1;
`else
  localparam bit OUTREG = 1'b0;
`endif

  typedef struct packed {
    logic [LW-1:0] lane;
    logic [W-1:0]  res;
    logic [4:0]    st;
    logic          ext;
    logic [TW-1:0] tag;
  } rec_t;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic in_valid_i = 1'b0, flush_i = 1'b0, out_ready_i = 1'b0;
  logic [LW-1:0] in_lane_i = '0;
  logic in_ready_o, out_valid_o, extension_bit_o, busy_o, order_err_o;
  logic [NL-1:0] lane_in_valid_o, lane_out_ready_o, lane_out_valid_i;
  logic [NL-1:0] lane_in_ready_i = '0, lane_busy_i = '0, lane_avail = '0, lane_bogus = '0, lane_has = '0;
  logic [NL*W-1:0] lane_result_i = '0;
  logic [NL*5-1:0] lane_status_i = '0;
  logic [NL-1:0] lane_ext_bit_i = '0;
  logic [NL*TW-1:0] lane_tag_i = '0;
  logic [W-1:0] result_o;
  logic [4:0] status_o;
  logic [TW-1:0] tag_o;
  logic [CW-1:0] occupancy_o;
  logic [W-1:0] next_val = '0;

  rec_t iq[$];
  rec_t oreg_r;
  bit oreg_v = 1'b0;
  bit m_err = 1'b0;
  logic [W-1:0] got_q[$];
  int checks = 0;
  int failures = 0;

  assign lane_out_valid_i = (lane_has & lane_avail) | lane_bogus;

  fpnew_opgroup_inorder_block dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_lane_i(in_lane_i),
    .in_ready_o(in_ready_o), .flush_i(flush_i), .lane_in_valid_o(lane_in_valid_o),
    .lane_in_ready_i(lane_in_ready_i), .lane_out_valid_i(lane_out_valid_i),
    .lane_out_ready_o(lane_out_ready_o), .lane_result_i(lane_result_i),
    .lane_status_i(lane_status_i), .lane_ext_bit_i(lane_ext_bit_i), .lane_tag_i(lane_tag_i),
    .lane_busy_i(lane_busy_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .status_o(status_o), .extension_bit_o(extension_bit_o),
    .tag_o(tag_o), .busy_o(busy_o), .order_err_o(order_err_o), .occupancy_o(occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Each lane presents its oldest result that has not yet been handed to the block
  always @(posedge clk_i) begin
    #1;
    lane_has = '0;
    for (int l = 0; l < NL; l++) begin
      lane_result_i[l*W +: W] = 32'hDEAD_0000 + 32'(l);
      lane_status_i[l*5 +: 5] = 5'h1F;
      lane_ext_bit_i[l] = 1'b0;
      lane_tag_i[l*TW +: TW] = '0;
      for (int k = iq.size() - 1; k >= 0; k--) begin
        if (int'(iq[k].lane) == l) begin
          lane_has[l] = 1'b1;
          lane_result_i[l*W +: W] = iq[k].res;
          lane_status_i[l*5 +: 5] = iq[k].st;
          lane_ext_bit_i[l] = iq[k].ext;
          lane_tag_i[l*TW +: TW] = iq[k].tag;
        end
      end
    end
  end

  // Scoreboard: issue-order queue model, compared every cycle then advanced
  always @(negedge clk_i) begin : sb
    bit full, inr, e_inrdy, e_take, e_fvld, e_pop, e_outv, e_busy;
    logic [NL-1:0] e_liv, e_lor;
    rec_t e_rec, n_rec;
    int fl, cnt;
    if (!rst_ni) begin
      iq.delete();
      m_err = 1'b0;
      oreg_v = 1'b0;
    end else begin
      full = (iq.size() == D);
      inr = (int'(in_lane_i) < NL);
      e_inrdy = 1'b0;
      e_liv = '0;
      if (in_valid_i && !full && !flush_i && inr) begin
        e_inrdy = lane_in_ready_i[in_lane_i];
        e_liv[in_lane_i] = 1'b1;
      end
      e_take = OUTREG ? (!oreg_v || out_ready_i) : out_ready_i;
      fl = (iq.size() > 0) ? int'(iq[0].lane) : -1;
      e_lor = '0;
      if (e_take && fl >= 0 && !flush_i) e_lor[fl] = 1'b1;
      e_fvld = (fl >= 0) && lane_out_valid_i[fl];
      e_pop = e_fvld && e_take && !flush_i;
      e_rec = '0;
      if (OUTREG) begin
        e_outv = oreg_v;
        e_rec = oreg_r;
      end else begin
        e_outv = e_fvld;
        if (fl >= 0) e_rec = iq[0];
      end
      e_busy = (iq.size() > 0) || (|lane_busy_i) || (OUTREG && oreg_v);

      checks += 7;
      if (in_ready_o !== e_inrdy) begin failures++; $display("FAIL sb_in_ready got=%b exp=%b t=%0t", in_ready_o, e_inrdy, $time); end
      if (lane_in_valid_o !== e_liv) begin failures++; $display("FAIL sb_lane_in_valid got=%b exp=%b t=%0t", lane_in_valid_o, e_liv, $time); end
      if (lane_out_ready_o !== e_lor) begin failures++; $display("FAIL sb_lane_out_ready got=%b exp=%b t=%0t", lane_out_ready_o, e_lor, $time); end
      if (out_valid_o !== e_outv) begin failures++; $display("FAIL sb_out_valid got=%b exp=%b t=%0t", out_valid_o, e_outv, $time); end
      if (occupancy_o !== CW'(iq.size())) begin failures++; $display("FAIL sb_occupancy got=%0d exp=%0d t=%0t", occupancy_o, iq.size(), $time); end
      if (order_err_o !== m_err) begin failures++; $display("FAIL sb_order_err got=%b exp=%b t=%0t", order_err_o, m_err, $time); end
      if (busy_o !== e_busy) begin failures++; $display("FAIL sb_busy got=%b exp=%b t=%0t", busy_o, e_busy, $time); end
      if (e_outv) begin
        checks++;
        if (result_o !== e_rec.res || status_o !== e_rec.st || extension_bit_o !== e_rec.ext || tag_o !== e_rec.tag) begin
          failures++;
          $display("FAIL sb_out_data got=%h/%h/%b/%b exp=%h/%h/%b/%b t=%0t", result_o, status_o, extension_bit_o, tag_o,
                   e_rec.res, e_rec.st, e_rec.ext, e_rec.tag, $time);
        end
      end
      if (out_valid_o === 1'b1 && out_ready_i) got_q.push_back(result_o);

      if (flush_i) begin
        iq.delete();
        m_err = 1'b0;
        oreg_v = 1'b0;
      end else begin
        for (int l = 0; l < NL; l++) begin
          cnt = 0;
          foreach (iq[k]) if (int'(iq[k].lane) == l) cnt++;
          if (lane_out_valid_i[l] && cnt == 0) m_err = 1'b1;
        end
        if (OUTREG && e_take) begin
          oreg_v = e_pop;
          if (e_pop) oreg_r = iq[0];
        end
        if (e_pop) void'(iq.pop_front());
        if (e_inrdy) begin
          n_rec.lane = in_lane_i;
          n_rec.res = next_val;
          n_rec.st = 5'($urandom);
          n_rec.ext = 1'($urandom);
          n_rec.tag = TW'($urandom);
          iq.push_back(n_rec);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic drain();
    in_valid_i = 1'b0; flush_i = 1'b0; lane_bogus = '0; lane_avail = '1; out_ready_i = 1'b1;
    for (int i = 0; i < 60 && (iq.size() > 0 || oreg_v); i++) step();
    checks++;
    if (iq.size() > 0 || oreg_v) begin failures++; $display("FAIL drain_timeout left=%0d exp=0", iq.size()); end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #3;
    checks += 4;
    if (out_valid_o !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid_o); end
    if (occupancy_o !== 4'd0) begin failures++; $display("FAIL rst_occupancy got=%0d exp=0", occupancy_o); end
    if (order_err_o !== 1'b0) begin failures++; $display("FAIL rst_order_err got=%b exp=0", order_err_o); end
    if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
    lane_busy_i = 5'b00100;
    #1;
    checks++;
    if (busy_o !== 1'b1) begin failures++; $display("FAIL rst_busy_lane got=%b exp=1", busy_o); end
    lane_busy_i = '0;
    step(); step();
    rst_ni = 1'b1;
    in_valid_i = 1'b1; in_lane_i = 3'd2; lane_avail = '1; out_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      lane_in_ready_i = 5'($urandom);
      next_val = $urandom;
      #1;
      checks++;
      if (in_ready_o !== lane_in_ready_i[2]) begin failures++; $display("FAIL idle_in_ready got=%b exp=%b", in_ready_o, lane_in_ready_i[2]); end
      step();
    end
    drain();
  endtask

  task automatic test_order();
    got_q.delete();
    lane_in_ready_i = '1; lane_avail = '0; out_ready_i = 1'b1;
    in_valid_i = 1'b1; in_lane_i = 3'd2; next_val = 32'h0000_2222;
    step();
    in_lane_i = 3'd0; next_val = 32'h0000_1111;
    step();
    in_lane_i = 3'd1; next_val = 32'h0000_AAAA;
    step();
    in_valid_i = 1'b0; lane_avail = 5'b00010;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) lane_avail = 5'b00011;
      step();
      #1;
      checks += 2;
      if (out_valid_o !== 1'b0) begin failures++; $display("FAIL order_hold_valid got=%b exp=0", out_valid_o); end
      if (lane_out_ready_o[1] !== 1'b0) begin failures++; $display("FAIL order_lane1_ready got=%b exp=0", lane_out_ready_o[1]); end
    end
    drain();
    checks++;
    if (got_q.size() != 3) begin
      failures++; $display("FAIL order_count got=%0d exp=3", got_q.size());
    end else begin
      checks += 3;
      if (got_q[0] !== 32'h0000_2222) begin failures++; $display("FAIL order_first got=%h exp=00002222", got_q[0]); end
      if (got_q[1] !== 32'h0000_1111) begin failures++; $display("FAIL order_second got=%h exp=00001111", got_q[1]); end
      if (got_q[2] !== 32'h0000_AAAA) begin failures++; $display("FAIL order_third got=%h exp=0000aaaa", got_q[2]); end
    end
  endtask

  task automatic test_full();
    lane_in_ready_i = '1; out_ready_i = 1'b0; lane_avail = '1; in_valid_i = 1'b1;
    for (int i = 0; i < 20 && iq.size() < D; i++) begin
      in_lane_i = 3'($urandom_range(4, 0)); next_val = $urandom;
      step();
    end
    #1;
    checks += 2;
    if (occupancy_o !== 4'd8) begin failures++; $display("FAIL full_occupancy got=%0d exp=8", occupancy_o); end
    if (in_ready_o !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", in_ready_o); end
    out_ready_i = 1'b1;
    #1;
    checks++;
    if (in_ready_o !== 1'b0) begin failures++; $display("FAIL full_pop_in_ready got=%b exp=0", in_ready_o); end
    step();
    out_ready_i = 1'b0;
    #1;
    checks += 2;
    if (occupancy_o !== 4'd7) begin failures++; $display("FAIL full_after_pop got=%0d exp=7", occupancy_o); end
    if (in_ready_o !== 1'b1) begin failures++; $display("FAIL full_refill_ready got=%b exp=1", in_ready_o); end
    step();
    in_valid_i = 1'b0;
    #1;
    checks++;
    if (occupancy_o !== 4'd8) begin failures++; $display("FAIL full_refilled got=%0d exp=8", occupancy_o); end
    drain();
  endtask

  task automatic test_order_err();
    lane_avail = '0;
    step();
    lane_bogus = 5'b01000;
    step();
    lane_bogus = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (order_err_o !== 1'b1) begin failures++; $display("FAIL order_err_set got=%b exp=1", order_err_o); end
      step();
    end
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    #1;
    checks++;
    if (order_err_o !== 1'b0) begin failures++; $display("FAIL order_err_flush got=%b exp=0", order_err_o); end
    drain();
  endtask

  task automatic test_flush();
    lane_in_ready_i = '1; lane_avail = '0; out_ready_i = 1'b1; in_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_lane_i = 3'($urandom_range(4, 0)); next_val = $urandom;
      step();
    end
    flush_i = 1'b1;
    #1;
    checks += 2;
    if (in_ready_o !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", in_ready_o); end
    if (occupancy_o !== 4'd5) begin failures++; $display("FAIL flush_pre_occ got=%0d exp=5", occupancy_o); end
    step();
    flush_i = 1'b0; in_valid_i = 1'b0; lane_avail = '1;
    #1;
    checks += 2;
    if (occupancy_o !== 4'd0) begin failures++; $display("FAIL flush_occupancy got=%0d exp=0", occupancy_o); end
    if (out_valid_o !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b exp=0", out_valid_o); end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid_i = 1'($urandom);
      in_lane_i = 3'($urandom_range(7, 0));
      next_val = $urandom;
      lane_in_ready_i = 5'($urandom);
      lane_avail = 5'($urandom);
      lane_busy_i = 5'($urandom_range(31, 0)) & 5'($urandom);
      out_ready_i = ($urandom_range(3, 0) != 0);
      flush_i = ($urandom_range(31, 0) == 0);
      lane_bogus = ($urandom_range(63, 0) == 0) ? 5'(1 << $urandom_range(4, 0)) : 5'b0;
      step();
    end
    lane_busy_i = '0;
    drain();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
  endtask

`ifdef FPNEW_INORDER_OUTREG_EN
  task automatic test_outreg();
    lane_in_ready_i = '1; lane_avail = '1; out_ready_i = 1'b1;
    in_valid_i = 1'b1; in_lane_i = 3'd0; next_val = 32'h5A5A_0001;
    step();
    in_valid_i = 1'b0;
    #1;
    checks++;
    if (out_valid_o !== 1'b0) begin failures++; $display("FAIL oreg_latency0 got=%b exp=0", out_valid_o); end
    step();
    #1;
    checks++;
    if (out_valid_o !== 1'b1) begin failures++; $display("FAIL oreg_latency1 got=%b exp=1", out_valid_o); end
    drain();
    out_ready_i = 1'b0; in_valid_i = 1'b1; in_lane_i = 3'd3; next_val = 32'h0000_0077;
    step();
    in_valid_i = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (out_valid_o !== 1'b1 || result_o !== 32'h0000_0077) begin
        failures++; $display("FAIL oreg_hold got=%b/%h exp=1/00000077", out_valid_o, result_o);
      end
      step();
    end
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_order();
    test_full();
    test_order_err();
    test_flush();
`ifdef FPNEW_INORDER_OUTREG_EN
    test_outreg();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpnew_opgroup_inorder_block.md
Name: fpnew_opgroup_inorder_block

Overview:
Parametrised successor to the per-opgroup result collector. It dispatches operations to NumLanes independent, internally in-order format/lane slices and retires their results strictly in issue order through an issue-order FIFO of lane indices, where the previous generation used round-robin arbitration. It sits between the opgroup dispatch logic and the FPU output stage. Lane slices are external; this block owns only dispatch steering, ordering, flush and error tracking.

Parameters:
Width, 32, result datapath width in bits
NumLanes, 5, number of attached lane slices (>=1)
Depth, 8, maximum in-flight operations across all lanes (>=2, power of two)
TagWidth, 1, width of the opaque tag carried with each result
LaneIdxW, max(1,$clog2(NumLanes)), localparam: lane index width
CntW, $clog2(Depth+1), localparam: occupancy counter width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
in_valid_i  in  1  operation offered for dispatch
in_lane_i  in  LaneIdxW  target lane of offered operation
in_ready_o  out  1  operation accepted this cycle
flush_i  in  1  discard all in-flight ordering state
lane_in_valid_o  out  NumLanes  per-lane dispatch valid
lane_in_ready_i  in  NumLanes  per-lane dispatch ready
lane_out_valid_i  in  NumLanes  per-lane result valid
lane_out_ready_o  out  NumLanes  per-lane result ready
lane_result_i  in  NumLanes*Width  per-lane results
lane_status_i  in  NumLanes*5  per-lane fpnew status flags
lane_ext_bit_i  in  NumLanes  per-lane extension bit
lane_tag_i  in  NumLanes*TagWidth  per-lane tags
lane_busy_i  in  NumLanes  per-lane busy
out_valid_o  out  1  retired result valid
out_ready_i  in  1  downstream ready
result_o  out  Width  retired result
status_o  out  5  retired status
extension_bit_o  out  1  retired extension bit
tag_o  out  TagWidth  retired tag
busy_o  out  1  ops in flight
order_err_o  out  1  sticky: lane produced a result out of order
occupancy_o  out  CntW  current in-flight count

Behaviour:
- Single clock clk_i; reset is asynchronous and active-low (rst_ni). Reset: FIFO head/tail/count = 0, order_err_o = 0, occupancy_o = 0, out_valid_o = 0, busy_o = lane_busy_i OR-reduce only.
- full = (count == Depth); empty = (count == 0).
- Dispatch: in_ready_o = in_valid_i & !full & !flush_i & (in_lane_i < NumLanes) & lane_in_ready_i[in_lane_i]. lane_in_valid_o[l] = in_valid_i & !full & !flush_i & (in_lane_i == l). Push of in_lane_i at tail when in_valid_i & in_ready_o.
- Out-of-range in_lane_i: no lane_in_valid_o asserted, in_ready_o = 0, no push.
- Retire: head_lane = FIFO[head]. out_valid_o = !empty & lane_out_valid_i[head_lane]. Outputs mux the head lane's result/status/ext/tag combinationally (zero added latency); value is don't-care when out_valid_o = 0.
- lane_out_ready_o[l] = out_ready_i & !empty & !flush_i & (head_lane == l); all other bits 0. Pop when out_valid_o & out_ready_i.
- Full: no push, even if a pop occurs in the same cycle (ready not combinationally dependent on out_ready_i).
- Push + pop in the same cycle (not full): count unchanged, both pointers advance; pointers wrap modulo Depth.
- Per-lane outstanding counters (CntW bits): +1 on dispatch to lane, -1 on retire from lane. order_err_o sets (sticky until reset or flush) when lane_out_valid_i[l] = 1 while the outstanding count of lane l is 0.
- Flush: when flush_i = 1, the next state is head = tail = count = 0 and all lane counters and order_err_o cleared; during the flush cycle no push and no pop. Lanes are flushed externally by the same signal.
- occupancy_o = count. busy_o = !empty | (|lane_busy_i).

Optional Feature:
FPNEW_INORDER_OUTREG_EN: when defined, a single-entry output register sits after the retire mux. The pop is taken into the register when the register is empty or is being drained in the same cycle. out_valid_o and all data ports come from the register, so latency is 1 cycle and data is held stable while out_ready_i = 0. Flush clears register valid, and reset clears register valid to 0. When not defined, retire is combinational as above.

Test Plan:
- Reset then idle -> out_valid_o=0, in_ready_o follows lane_in_ready_i, occupancy_o=0, order_err_o=0.
- Dispatch lanes 2,0,1. Lane 1 returns 0xAAAA first, then lane 0 returns 0x1111, then lane 2 returns 0x2222 -> retire order is 0x2222, 0x1111, 0xAAAA; lane 1 held with ready=0 until it reaches head.
- Fill 8 ops with out_ready_i=0 -> 9th op sees in_ready_o=0 and occupancy_o=8. Single pop with simultaneous valid -> next cycle accepts, occupancy back to 8. Tail wraps correctly.
- lane_out_valid_i[3]=1 with no op dispatched to lane 3 -> order_err_o=1 next cycle and stays set. Flush -> order_err_o=0.
- Flush with 5 in flight and simultaneous in_valid_i -> in_ready_o=0 that cycle, occupancy_o=0 next cycle, no out_valid_o.
- With FPNEW_INORDER_OUTREG_EN: single op -> out_valid_o rises 1 cycle later than without the macro. Stall out_ready_i=0 for 3 cycles -> result_o held constant.
